// File: rtl/inv_key_exp.sv
// Inverse AES key expansion: reconstructs round key N-1 from round key N, byte-serial, external S-box.
// Optional INV_KEY_RCON_TABLE_EN derives Rcon from the round port instead of the rcon port.
module inv_key_exp (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       enable_din,
  input  logic [7:0] rcon,
  input  logic [3:0] round,
  output logic [7:0] addr_out,
  output logic       enable_sbox,
  input  logic [7:0] sbox_in,
  input  logic       round_complete,
  output logic [7:0] dout,
  output logic       enable_out,
  output logic       busy
);

  // state | meaning
  // LOAD  | collect 16 key bytes (row-major) on enable_din
  // XOR   | columns 1..3 of the previous key from adjacent-column XOR
  // SBOX  | four RotWord lookups issued, results captured one cycle later
  // COL0  | column 0 from SubWord result and Rcon
  // WAIT  | hold the result until round_complete
  // OUT   | stream 16 bytes on dout
  typedef enum logic [2:0] {S_LOAD, S_XOR, S_SBOX, S_COL0, S_WAIT, S_OUT} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] key_q  [16];
  logic [7:0] key_d  [16];
  logic [7:0] prev_q [16];
  logic [7:0] prev_d [16];
  logic [7:0] sub_q  [4];
  logic [7:0] sub_d  [4];
  logic [7:0] addr_q, addr_d;
  logic [7:0] dout_q, dout_d;
  logic       en_sbox_q, en_sbox_d;
  logic       en_out_q, en_out_d;
  logic       busy_q, busy_d;
  logic [7:0] rcon_int;
  logic [1:0] nrow;

`ifdef INV_KEY_RCON_TABLE_EN
  logic unused_rcon;
  assign unused_rcon = ^rcon;

  always_comb begin
    rcon_int = 8'h00;
    case (round)
      4'd1:    rcon_int = 8'h01;
      4'd2:    rcon_int = 8'h02;
      4'd3:    rcon_int = 8'h04;
      4'd4:    rcon_int = 8'h08;
      4'd5:    rcon_int = 8'h10;
      4'd6:    rcon_int = 8'h20;
      4'd7:    rcon_int = 8'h40;
      4'd8:    rcon_int = 8'h80;
      4'd9:    rcon_int = 8'h1b;
      4'd10:   rcon_int = 8'h36;
      default: rcon_int = 8'h00;
    endcase
  end
`else
  logic unused_round;
  assign unused_round = ^round;
  assign rcon_int     = rcon;
`endif

  // Lookup k+1 targets word 3 of row (k+2) mod 4, giving the RotWord order.
  assign nrow = cnt_q[1:0] + 2'd2;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    prev_d    = prev_q;
    sub_d     = sub_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    en_sbox_d = 1'b0;
    en_out_d  = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        if (enable_din) begin
          key_d[cnt_q] = din;
          cnt_d        = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = S_XOR;
        end
      end
      S_XOR: begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 1; c < 4; c++) begin
            prev_d[4*r+c] = key_q[4*r+c] ^ key_q[4*r+c-1];
          end
        end
        addr_d    = key_q[7] ^ key_q[6];
        en_sbox_d = 1'b1;
        cnt_d     = 4'd0;
        state_d   = S_SBOX;
      end
      S_SBOX: begin
        if (cnt_q != 4'd0) sub_d[cnt_q[1:0] - 2'd1] = sbox_in;
        if (cnt_q < 4'd3) begin
          en_sbox_d = 1'b1;
          addr_d    = prev_q[{nrow, 2'b11}];
        end
        if (cnt_q == 4'd4) begin
          cnt_d   = 4'd0;
          state_d = S_COL0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_COL0: begin
        for (int r = 0; r < 4; r++) begin
          prev_d[4*r] = key_q[4*r] ^ sub_q[r];
        end
        prev_d[0] = key_q[0] ^ sub_q[0] ^ rcon_int;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (round_complete) begin
          en_out_d = 1'b1;
          dout_d   = prev_q[0];
          cnt_d    = 4'd0;
          state_d  = S_OUT;
        end
      end
      S_OUT: begin
        if (cnt_q == 4'd15) begin
          cnt_d   = 4'd0;
          state_d = S_LOAD;
        end else begin
          en_out_d = 1'b1;
          dout_d   = prev_q[cnt_q + 4'd1];
          cnt_d    = cnt_q + 4'd1;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = S_LOAD;
      end
    endcase
    busy_d = (state_d != S_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LOAD;
      cnt_q     <= 4'd0;
      addr_q    <= 8'h00;
      dout_q    <= 8'h00;
      en_sbox_q <= 1'b0;
      en_out_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      en_sbox_q <= en_sbox_d;
      en_out_q  <= en_out_d;
      busy_q    <= busy_d;
    end
  end

  // Key storage carries no reset; a reset restarts the load counter instead.
  always_ff @(posedge clk) begin
    key_q  <= key_d;
    prev_q <= prev_d;
    sub_q  <= sub_d;
  end

  assign addr_out    = addr_q;
  assign enable_sbox = en_sbox_q;
  assign dout        = dout_q;
  assign enable_out  = en_out_q;
  assign busy        = busy_q;

endmodule
